sqrt_result_buffer: RTL
=======================

Name: sqrt_result_buffer

Overview:
- Downstream companion of the non-stallable sqrt pipeline.
- Captures every root the pipeline produces into a small FIFO and presents it to the consumer over a valid/ready handshake.
- Gives credit-based back-pressure to the issuer: the issuer may launch a radicand only if a FIFO slot is guaranteed free when the result emerges, so no result is ever dropped.

Parameters:
- WIDTH_OUTPUT, 8, root width; must match the sqrt pipeline's output width.
- DEPTH, 8, FIFO entries; power of two, >= 2.
- LATENCY, 8, sqrt pipeline latency in cycles (equals WIDTH_OUTPUT of the pipeline); used only for assertions and the bench.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- issue_valid  input  1  issuer offers a radicand this cycle; same signal drives the pipeline's valid_in.
- issue_ready  output  1  issuer may launch this cycle; issuer gates valid_in with issue_valid & issue_ready.
- pipe_valid  input  1  pipeline valid_out.
- pipe_root  input  WIDTH_OUTPUT  pipeline root.
- out_valid  output  1  head FIFO entry available.
- out_ready  input  1  consumer accepts the head entry.
- out_root  output  WIDTH_OUTPUT  head FIFO entry.
- count  output  $clog2(DEPTH+1)  current FIFO occupancy.
- err_overflow  output  1  sticky: pipe_valid arrived with FIFO full.
- err_spurious  output  1  sticky: pipe_valid arrived with zero in-flight.

Behaviour:
- Reset: all state clears on the clk edge where rst_n=0. Resulting outputs:
  - count=0, inflight=0, pointers=0.
  - out_valid=0, issue_ready=1, out_root=0, err_* = 0.
  - Reset mid-operation discards FIFO contents and credits.
  - The pipeline is reset by the same rst_n, so no stale results arrive.
- Credit tracking:
  - issue = issue_valid & issue_ready.
  - inflight += issue, -= pipe_valid; both in the same cycle leaves it unchanged.
- Issue gating:
  - issue_ready = (count + inflight) < DEPTH.
  - Computed from registered state only; no combinational path from out_ready or issue_valid.
  - One-cycle-late credit release is accepted: a pop frees a credit visible the next cycle.
- FIFO:
  - Push on pipe_valid; pop on out_valid & out_ready.
  - out_valid = (count != 0).
  - out_root = mem[rd_ptr] with zero-cycle read: first-word fall-through, data visible the cycle after the push.
  - Push and pop in the same cycle leaves count unchanged; this is legal at full and at empty+push.
  - Pointers wrap modulo DEPTH.
- Overflow:
  - pipe_valid while count==DEPTH with no simultaneous pop: write is dropped, err_overflow sets, count stays DEPTH.
  - Unreachable when the issuer obeys issue_ready.
- Spurious result:
  - pipe_valid while inflight==0: data is still pushed if there is room, err_spurious sets, inflight saturates at 0.
- Error flags clear only on reset.
- Latency: root available at out_root LATENCY+1 cycles after the issue cycle, given an empty FIFO.
- Throughput: one result per cycle sustained when out_ready is held high.

Decomposition:
- Package sqrt_pkg:
  - SQRT_WIDTH_INPUT=16, SQRT_WIDTH_OUTPUT=8, SQRT_LATENCY=8, SQRT_BUF_DEPTH=8.
  - Count/pointer width functions.
- One sub-module: sqrt_result_fifo.
  - Generic synchronous FWFT FIFO: push, pop, din, dout, count, full, empty.
  - Synchronous active-low reset.
- Credit counter, issue gating and error flags stay in the top.

Test Plan (bench instantiates sqrt_generic, WIDTH_INPUT=16, feeding this block; DEPTH=8):
- Single issue of radicand 144, out_ready=1 -> out_valid rises 9 cycles after the issue cycle with out_root=12; count returns to 0 the cycle after.
- Back-to-back issues 0, 1, 65535, 143 with out_ready=1 -> in-order roots 0, 1, 255, 11 on consecutive cycles; no error flags.
- out_ready=0, issue_valid held high -> exactly 8 issues accepted, issue_ready=0 from the cycle count+inflight hits 8, count settles at 8, err_overflow stays 0. Then a single pop -> issue_ready=1 the next cycle and exactly one further issue is accepted.
- Full FIFO, pipe_valid and pop in the same cycle (forced) -> count stays 8, new root lands at the tail, no error.
- Force pipe_valid with FIFO full and out_ready=0 -> err_overflow=1, count=8, head data unchanged. Force pipe_valid with inflight=0 -> err_spurious=1.
- Assert rst_n=0 for one cycle with 5 entries buffered and 3 in flight -> next cycle count=0, out_valid=0, issue_ready=1, err flags 0; no stale roots emerge afterwards.

Source files
------------

// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared sizes and width helpers for the sqrt datapath
package sqrt_pkg;

  localparam int SQRT_WIDTH_INPUT  = 16;
  localparam int SQRT_WIDTH_OUTPUT = 8;
  localparam int SQRT_LATENCY      = 8;
  localparam int SQRT_BUF_DEPTH    = 8;

  // Occupancy counters must be able to hold the value DEPTH itself.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sqrt_result_fifo.sv
// rtl/sqrt_result_fifo.sv - synchronous first-word-fall-through FIFO
module sqrt_result_fifo
  import sqrt_pkg::*;
#(
  parameter int WIDTH = SQRT_WIDTH_OUTPUT,
  parameter int DEPTH = SQRT_BUF_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push_i,
  input  logic                        pop_i,
  input  logic [WIDTH-1:0]            din_i,
  output logic [WIDTH-1:0]            dout_o,
  output logic [cnt_width(DEPTH)-1:0] count_o,
  output logic                        full_o,
  output logic                        empty_o
);

  localparam int CW = cnt_width(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  // Empty slots read as zero so the head never shows stale data.
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A push into a full FIFO is still accepted when the head leaves this cycle.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/sqrt_result_buffer.sv
// rtl/sqrt_result_buffer.sv - credit-gated result buffer behind the sqrt pipeline
module sqrt_result_buffer
  import sqrt_pkg::*;
#(
  parameter int WIDTH_OUTPUT = SQRT_WIDTH_OUTPUT,
  parameter int DEPTH        = SQRT_BUF_DEPTH,
  parameter int LATENCY      = SQRT_LATENCY
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        issue_valid,
  output logic                        issue_ready,
  input  logic                        pipe_valid,
  input  logic [WIDTH_OUTPUT-1:0]     pipe_root,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH_OUTPUT-1:0]     out_root,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        err_overflow,
  output logic                        err_spurious
);

  localparam int CW = cnt_width(DEPTH);

  logic [CW-1:0] inflight_q, inflight_d;
  logic          err_overflow_q, err_overflow_d;
  logic          err_spurious_q, err_spurious_d;
  logic [CW:0]   committed;
  logic          issue, pop, retire, fifo_full, fifo_empty;

  sqrt_result_fifo #(
    .WIDTH (WIDTH_OUTPUT),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (pipe_valid),
    .pop_i   (pop),
    .din_i   (pipe_root),
    .dout_o  (out_root),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;

  // Slots already owned by buffered plus in-flight results; registered state only.
  assign committed   = {1'b0, count} + {1'b0, inflight_q};
  assign issue_ready = (committed < (CW+1)'(DEPTH));
  assign issue       = issue_valid & issue_ready;
  assign retire      = pipe_valid & (inflight_q != '0);

  always_comb begin
    inflight_d     = inflight_q + CW'(issue) - CW'(retire);
    err_overflow_d = err_overflow_q | (pipe_valid & fifo_full & ~pop);
    err_spurious_d = err_spurious_q | (pipe_valid & (inflight_q == '0));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_q     <= '0;
      err_overflow_q <= 1'b0;
      err_spurious_q <= 1'b0;
    end else begin
      inflight_q     <= inflight_d;
      err_overflow_q <= err_overflow_d;
      err_spurious_q <= err_spurious_d;
    end
  end

  assign err_overflow = err_overflow_q;
  assign err_spurious = err_spurious_q;

  // The pipeline can never hold more than one result per stage.
  a_inflight_bound : assert property (@(posedge clk) disable iff (!rst_n)
    inflight_q <= CW'(LATENCY));

endmodule
